shift_seq: RTL

- Multi-cycle iterative shifter/rotator for the 16-bit ALU.
- It is the sequential counterpart of the combinational barrel shifter: the same four shift ops, but applied serially, at most 2 bit positions per cycle.
- It sits beside the ALU and is started by the execute stage when a cheap, area-minimal shift path is selected.
- It uses a start/busy/done handshake, and the result is held until the next completion.

---
 rtl/shift_seq_pkg.sv | 25 ++
 rtl/shift_step.sv | 26 ++
 rtl/shift_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared ALU shift definitions: op encodings, sequencer states and widths.
package shift_seq_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        OP_ROL = 2'd0,
        OP_SLL = 2'd1,
        OP_ROR = 2'd2,
        OP_ASR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Number of bit positions a single RUN cycle consumes from the remaining count.
    function automatic logic [CNT_W-1:0] step_size(input logic two_n);
        return two_n ? CNT_W'(2) : CNT_W'(1);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One serial shift step of 1 or 2 bit positions for any of the four shift ops.
module shift_step
    import shift_seq_pkg::*;
(
    input  logic [WIDTH-1:0] in,
    input  op_e              op,
    input  logic             two_n,
    output logic [WIDTH-1:0] out_c
);

    always_comb begin
        out_c = in;
        unique case (op)
            OP_ROL: out_c = two_n ? {in[WIDTH-3:0], in[WIDTH-1:WIDTH-2]}
                                  : {in[WIDTH-2:0], in[WIDTH-1]};
            OP_SLL: out_c = two_n ? {in[WIDTH-3:0], 2'b00}
                                  : {in[WIDTH-2:0], 1'b0};
            OP_ROR: out_c = two_n ? {in[1:0], in[WIDTH-1:2]}
                                  : {in[0], in[WIDTH-1:1]};
            OP_ASR: out_c = two_n ? {{2{in[WIDTH-1]}}, in[WIDTH-1:2]}
                                  : {in[WIDTH-1], in[WIDTH-1:1]};
            default: out_c = in;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Iterative shifter/rotator: consumes up to two bit positions per cycle,
// start/busy/done handshake, result held until the next completion.
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    state_e           state;
    op_e              op_r;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] rem;

    logic             two_n;
    logic [WIDTH-1:0] step_c;
    logic [CNT_W-1:0] rem_nxt_c;

    assign two_n     = (rem >= CNT_W'(2));
    assign rem_nxt_c = rem - step_size(two_n);

    shift_step u_step (
        .in    (acc),
        .op    (op_r),
        .two_n (two_n),
        .out_c (step_c)
    );

    // Sequencer: out/done are loaded on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_r  <= OP_ROL;
            acc   <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= in;
                        op_r <= op_e'(op);
                        rem  <= cnt;
                        busy <= 1'b1;
                        if (cnt == '0) begin
                            state <= S_DONE;
                            out   <= in;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= step_c;
                    rem <= rem_nxt_c;
                    if (rem_nxt_c == '0) begin
                        state <= S_DONE;
                        out   <= step_c;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
